// File: rtl/constellation_mapper_pkg.sv
// Shared types and constants for the constellation mapper: modulation encoding,
// bits-per-symbol and constellation table layout.
package constellation_mapper_pkg;

  typedef enum logic [1:0] {
    MOD_QPSK   = 2'd0,
    MOD_8PSK   = 2'd1,
    MOD_16APSK = 2'd2,
    MOD_32APSK = 2'd3
  } mod_e;

  localparam int unsigned LUT_AW            = 6;
  localparam int unsigned LUT_DEPTH         = 1 << LUT_AW;
  localparam int unsigned MAX_BPS           = 5;
  localparam int unsigned BUF_PAD           = 4;
  localparam int unsigned DEF_DATA_IN_WIDTH = 8;
  localparam int unsigned BUF_W             = DEF_DATA_IN_WIDTH + BUF_PAD;

  // Each modulation's points sit right after the previous modulation's points.
  localparam logic [LUT_AW-1:0] BASE_QPSK   = 6'd0;
  localparam logic [LUT_AW-1:0] BASE_8PSK   = 6'd4;
  localparam logic [LUT_AW-1:0] BASE_16APSK = 6'd12;
  localparam logic [LUT_AW-1:0] BASE_32APSK = 6'd28;

  function automatic logic [2:0] bps_of(input mod_e m);
    logic [2:0] r;
    case (m)
      MOD_QPSK:   r = 3'd2;
      MOD_8PSK:   r = 3'd3;
      MOD_16APSK: r = 3'd4;
      default:    r = 3'd5;
    endcase
    return r;
  endfunction

  function automatic logic [LUT_AW-1:0] base_of(input mod_e m);
    logic [LUT_AW-1:0] r;
    case (m)
      MOD_QPSK:   r = BASE_QPSK;
      MOD_8PSK:   r = BASE_8PSK;
      MOD_16APSK: r = BASE_16APSK;
      default:    r = BASE_32APSK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/constellation_mapper_lut_ram.sv
// Simple dual-port constellation table: independent write port, registered
// read-first read port with enable. Only the read register is reset.
module constellation_lut_ram
  import constellation_mapper_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [LUT_AW-1:0] waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic              re_i,
  input  logic [LUT_AW-1:0] raddr_i,
  output logic [DW-1:0]     rdata_o
);

  logic [DW-1:0] mem_q [LUT_DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Non-blocking read of the array gives old data on a same-address write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/constellation_mapper.sv
// Byte-stream to I/Q symbol mapper: unpacks frames MSB-first into 2..5-bit
// groups and looks each group up in a writable constellation table.
module constellation_mapper
  import constellation_mapper_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH = 8,
  parameter int unsigned IQ_WIDTH      = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [1:0]               cfg_modulation,
  input  logic [DATA_IN_WIDTH-1:0] s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  output logic [2*IQ_WIDTH-1:0]    m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  input  logic                     lut_wren,
  input  logic [LUT_AW-1:0]        lut_addr,
  input  logic [2*IQ_WIDTH-1:0]    lut_wdata
);

  localparam int unsigned BW = DATA_IN_WIDTH + BUF_PAD;
  localparam int unsigned CW = $clog2(BW + 1);
  // A beat fits when the post-pop fill leaves at least one beat of space.
  localparam logic [CW-1:0] ROOM = CW'(BW - DATA_IN_WIDTH);

  // Handshake: a beat transfers on s_tvalid & s_tready, a symbol on
  // m_tvalid & m_tready; both may happen in the same cycle.
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_pend_q, last_pend_d;
  logic          frame_act_q, frame_act_d;
  mod_e          mod_q, mod_d;
  logic          valid_q, tlast_q;
  logic          rdy_en_q;

  logic              advance, pop, accept, frame_end;
  logic [2:0]        bps3;
  logic [CW-1:0]     bps_w, take, cnt_after_pop;
  logic [MAX_BPS-1:0] top_bits, sym_bits;
  logic [LUT_AW-1:0] rd_addr;

  assign bps3          = bps_of(mod_q);
  assign bps_w         = CW'(bps3);
  assign advance       = !valid_q || m_tready;
  assign pop           = advance && ((cnt_q >= bps_w) || (last_pend_q && (cnt_q != '0)));
  assign take          = (cnt_q < bps_w) ? cnt_q : bps_w;
  assign frame_end     = pop && last_pend_q && (cnt_q <= bps_w);
  assign cnt_after_pop = pop ? (cnt_q - take) : cnt_q;
  assign s_tready      = rdy_en_q && !last_pend_q && (cnt_after_pop <= ROOM);
  assign accept        = s_tvalid && s_tready;

  // Bits below cnt_q are always zero, so a short tail is already zero-padded.
  assign top_bits = buf_q[BW-1 -: MAX_BPS];
  assign sym_bits = top_bits >> (3'(MAX_BPS) - bps3);
  assign rd_addr  = base_of(mod_q) + LUT_AW'(sym_bits);

  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    last_pend_d = last_pend_q;
    frame_act_d = frame_act_q;
    mod_d       = mod_q;
    if (pop) begin
      buf_d = buf_q << take;
      cnt_d = cnt_q - take;
    end
    if (accept) begin
      buf_d = buf_d | ({s_tdata, {BUF_PAD{1'b0}}} >> cnt_d);
      cnt_d = cnt_d + CW'(DATA_IN_WIDTH);
      if (!frame_act_q) begin
        mod_d       = mod_e'(cfg_modulation);
        frame_act_d = 1'b1;
      end
      if (s_tlast) last_pend_d = 1'b1;
    end
    if (frame_end) begin
      last_pend_d = 1'b0;
      frame_act_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
      frame_act_q <= 1'b0;
      mod_q       <= MOD_QPSK;
      valid_q     <= 1'b0;
      tlast_q     <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      last_pend_q <= last_pend_d;
      frame_act_q <= frame_act_d;
      mod_q       <= mod_d;
      rdy_en_q    <= 1'b1;
      if (advance) begin
        valid_q <= pop;
        tlast_q <= frame_end;
      end
    end
  end

  constellation_lut_ram #(
    .DW(2*IQ_WIDTH)
  ) u_lut (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .we_i    (lut_wren),
    .waddr_i (lut_addr),
    .wdata_i (lut_wdata),
    .re_i    (advance),
    .raddr_i (rd_addr),
    .rdata_o (m_tdata)
  );

  assign m_tvalid = valid_q;
  assign m_tlast  = tlast_q;

endmodule

// File: tb/tb_constellation_mapper.sv
// Self-checking bench for constellation_mapper: a bit-queue reference model
// predicts {tlast, I/Q} per symbol; a negedge monitor scores the output stream.
module tb_constellation_mapper;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [1:0]  cfg_modulation = 2'd0;
  logic [7:0]  s_tdata = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        lut_wren = 1'b0;
  logic [5:0]  lut_addr = 6'd0;
  logic [31:0] lut_wdata = 32'd0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [32:0] exp_q[$];
  logic [31:0] lut_m [64];
  bit          rand_rdy = 1'b0;
  bit          stalled = 1'b0;
  logic [32:0] stall_val;
  logic [32:0] exp_v;

  constellation_mapper #(.DATA_IN_WIDTH(8), .IQ_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_modulation(cfg_modulation),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .lut_wren(lut_wren), .lut_addr(lut_addr), .lut_wdata(lut_wdata)
  );

  // ---------------- clock / ready generation ----------------
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge aclk) begin
    if (!aresetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        n_cmp++;
        if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== stall_val) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b %h required v=1 %h", m_tvalid, {m_tlast, m_tdata}, stall_val);
        end
      end
      stalled   = (m_tvalid === 1'b1) && (m_tready === 1'b0);
      stall_val = {m_tlast, m_tdata};
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_symbol: got %h required no symbol", {m_tlast, m_tdata});
        end else begin
          exp_v = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== exp_v) begin
            n_err++;
            $display("FAIL symbol: got last=%b iq=%h required last=%b iq=%h",
                     m_tlast, m_tdata, exp_v[32], exp_v[31:0]);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Group the MSB-first bit stream into bps-bit indices, zero-pad the tail;
  // each modulation's table region starts at 2^bps - 4 (sum of smaller sets).
  task automatic model_frame(input logic [7:0] bytes[$], input int mod);
    bit bits[$];
    int bps, base, idx;
    bps  = mod + 2;
    base = (1 << bps) - 4;
    foreach (bytes[i]) for (int b = 7; b >= 0; b--) bits.push_back(bytes[i][b]);
    while (bits.size() > 0) begin
      idx = 0;
      for (int k = 0; k < bps; k++) begin
        idx = idx * 2;
        if (bits.size() > 0) idx += int'(bits.pop_front());
      end
      exp_q.push_back({(bits.size() == 0) ? 1'b1 : 1'b0, lut_m[base + idx]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_lut(input logic [5:0] a, input logic [31:0] d);
    lut_addr = a; lut_wdata = d; lut_wren = 1'b1;
    @(posedge aclk); #1;
    lut_wren = 1'b0;
    lut_m[a] = d;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic last);
    int g = 0;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    @(negedge aclk);
    while (s_tready !== 1'b1 && g < 200) begin @(negedge aclk); g++; end
    if (g >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL beat_accept_timeout: s_tready=%b required 1 within 200 cycles", s_tready);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int mod);
    cfg_modulation = 2'(mod);
    foreach (bytes[i]) drive_beat(bytes[i], (i == bytes.size() - 1));
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin @(negedge aclk); g++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d symbols outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge aclk);
    @(negedge aclk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle: m_tvalid=%b required 0", name, m_tvalid);
    end
    @(posedge aclk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    n_cmp += 4;
    if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b required 0", m_tvalid); end
    if (m_tlast !== 1'b0)  begin n_err++; $display("FAIL reset_tlast: got %b required 0", m_tlast); end
    if (m_tdata !== 32'd0) begin n_err++; $display("FAIL reset_tdata: got %h required 0", m_tdata); end
    if (s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b required 0", s_tready); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    n_cmp++;
    if (s_tready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %b required 1", s_tready); end
    @(posedge aclk); #1;
    for (int a = 0; a < 64; a++) write_lut(6'(a), $urandom);
    write_lut(6'd0, 32'h2D41_2D41);
    write_lut(6'd1, 32'hD2BF_2D41);
    write_lut(6'd2, 32'h2D41_D2BF);
    write_lut(6'd3, 32'hD2BF_D2BF);
  endtask

  task automatic test_qpsk_latency();
    logic [7:0] fr[$];
    fr = '{8'h1B};
    model_frame(fr, 0);
    cfg_modulation = 2'd0;
    drive_beat(8'h1B, 1'b1);
    @(negedge aclk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL latency_early: m_tvalid=%b required 0", m_tvalid); end
    @(negedge aclk);
    n_cmp++;
    if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL latency_2cyc: m_tvalid=%b required 1", m_tvalid); end
    wait_drain("qpsk");
  endtask

  task automatic test_8psk_tail();
    logic [7:0] fr[$];
    fr = '{8'hFA, 8'h50};
    model_frame(fr, 1);
    send_frame(fr, 1);
    wait_drain("8psk");
  endtask

  task automatic test_32apsk_stream();
    logic [7:0] fr[$];
    int bubbles = 0;
    int g = 0;
    repeat (40) fr.push_back(8'($urandom));
    model_frame(fr, 3);
    fork
      send_frame(fr, 3);
      begin
        while (m_tvalid !== 1'b1 && g < 100) begin @(negedge aclk); g++; end
        for (int k = 1; k < 64; k++) begin
          @(negedge aclk);
          if (m_tvalid !== 1'b1) bubbles++;
        end
      end
    join
    n_cmp++;
    if (g >= 100 || bubbles != 0) begin
      n_err++;
      $display("FAIL stream_bubbles: got %0d bubbles (start wait %0d) required 0", bubbles, g);
    end
    wait_drain("32apsk");
  endtask

  task automatic test_stall_16apsk();
    logic [7:0] fr[$];
    repeat (12) fr.push_back(8'($urandom));
    model_frame(fr, 2);
    send_frame(fr, 2);
    wait_drain("16apsk_ready");
    rand_rdy = 1'b1;
    model_frame(fr, 2);
    send_frame(fr, 2);
    wait_drain("16apsk_stall");
    rand_rdy = 1'b0;
    repeat (2) @(posedge aclk); #1;
  endtask

  task automatic test_back_to_back_modchange();
    logic [7:0] fa[$];
    logic [7:0] fb[$];
    repeat (3) fa.push_back(8'($urandom));
    repeat (3) fb.push_back(8'($urandom));
    model_frame(fa, 0);
    model_frame(fb, 3);
    cfg_modulation = 2'd0;
    drive_beat(fa[0], 1'b0);
    cfg_modulation = 2'd3;
    drive_beat(fa[1], 1'b0);
    drive_beat(fa[2], 1'b1);
    @(negedge aclk);
    n_cmp++;
    if (s_tready !== 1'b0) begin n_err++; $display("FAIL ready_after_tlast: got %b required 0", s_tready); end
    @(posedge aclk); #1;
    send_frame(fb, 3);
    wait_drain("modchange");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] fr[$];
    repeat (5) fr.push_back(8'($urandom));
    model_frame(fr, 3);
    cfg_modulation = 2'd3;
    drive_beat(fr[0], 1'b0);
    drive_beat(fr[1], 1'b0);
    @(negedge aclk);
    aresetn = 1'b0;
    s_tvalid = 1'b0;
    #1;
    exp_q.delete();
    n_cmp += 4;
    if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL midreset_tvalid: got %b required 0", m_tvalid); end
    if (m_tlast !== 1'b0)  begin n_err++; $display("FAIL midreset_tlast: got %b required 0", m_tlast); end
    if (m_tdata !== 32'd0) begin n_err++; $display("FAIL midreset_tdata: got %h required 0", m_tdata); end
    if (s_tready !== 1'b0) begin n_err++; $display("FAIL midreset_tready: got %b required 0", s_tready); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk); #1;
    // Two 16APSK symbols, both index 12: first reads old entry, second the new one.
    exp_q.push_back({1'b0, lut_m[12]});
    exp_q.push_back({1'b1, 32'h1234_5678});
    cfg_modulation = 2'd2;
    drive_beat(8'h00, 1'b1);
    write_lut(6'd12, 32'h1234_5678);
    wait_drain("midreset");
  endtask

  initial begin
    test_reset();
    test_qpsk_latency();
    test_8psk_tail();
    test_32apsk_stream();
    test_stall_16apsk();
    test_back_to_back_modchange();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
